// File: rtl/fetch_stage.sv
// fetch_stage: owns the program counter, requests instructions from the
// icache and buffers each hit (with its PC) in a small circular queue that
// feeds decode over a valid/ready handshake. Redirects flush the queue and
// reload the PC.
module fetch_stage #(
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          LOG_QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] fetch_addr,
  output logic        icache_enable,
  input  logic [31:0] icache_inst,
  input  logic        icache_valid,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  input  logic        out_ready
);

  localparam logic [LOG_QUEUE_DEPTH:0]   DEPTH_C = QUEUE_DEPTH[LOG_QUEUE_DEPTH:0];
  localparam logic [LOG_QUEUE_DEPTH:0]   CNT_ONE = 1;
  localparam logic [LOG_QUEUE_DEPTH-1:0] PTR_ONE = 1;

  logic [63:0]                pc_q, pc_d;
  logic [LOG_QUEUE_DEPTH-1:0] head_q, head_d;
  logic [LOG_QUEUE_DEPTH-1:0] tail_q, tail_d;
  logic [LOG_QUEUE_DEPTH:0]   count_q, count_d;

  logic [63:0] qpc_q   [QUEUE_DEPTH];
  logic [31:0] qinst_q [QUEUE_DEPTH];

  logic full, empty, push, pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Enable deliberately ignores out_ready: a full queue only resumes fetching
  // the cycle after a pop, keeping decode's ready off the icache path.
  assign icache_enable = !reset && !redirect_valid && !full;
  assign fetch_addr    = pc_q;
  assign push          = icache_enable && icache_valid;

  assign out_valid = !reset && !empty;
  assign out_inst  = qinst_q[head_q];
  assign out_pc    = qpc_q[head_q];
  assign pop       = out_valid && out_ready;

  // Next-state for PC, pointers and occupancy; a redirect overrides everything.
  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[63:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + PTR_ONE;
        pc_d   = pc_q + 64'd4;
      end
      if (pop) begin
        head_d = head_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  // Control state register with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue storage: each entry captures {pc, inst} when the tail points at it.
  for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
    // Write entry gi on a push targeting it; storage needs no reset.
    always_ff @(posedge clk) begin
      if (push && (tail_q == LOG_QUEUE_DEPTH'(gi))) begin
        qpc_q[gi]   <= pc_q;
        qinst_q[gi] <= icache_inst;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed steps against an independent cycle model of the
// fetch stage; pushed instructions go to a scoreboard queue and are compared
// when they appear at the queue head.
module tb_fetch_stage;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] fetch_addr;
  logic        icache_enable;
  logic [31:0] icache_inst;
  logic        icache_valid;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_ready;

  fetch_stage #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH), .LOG_QUEUE_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .icache_enable(icache_enable),
    .icache_inst(icache_inst), .icache_valid(icache_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(logic [63:0] a);
    return a[31:0] ^ 32'hCAFE_0000;
  endfunction

  // icache stand-in: returns a word derived from the requested address
  assign icache_inst = inst_of(fetch_addr);

  int compared = 0;
  int mismatched = 0;

  // model state
  logic [63:0] mpc = RST_PC;
  int          mcount = 0;
  logic [95:0] sb[$];
  logic [63:0] popped[$];
  bit          record = 1'b0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model at the edge.
  task automatic cycle();
    logic exp_en, exp_valid, do_pop, do_push;
    #1;
    exp_en    = !reset && !redirect_valid && (mcount != DEPTH);
    exp_valid = !reset && (mcount != 0);
    chk("icache_enable", 64'(icache_enable), 64'(exp_en));
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    if (!reset) chk("fetch_addr", fetch_addr, mpc);
    if (exp_valid && sb.size() > 0) begin
      chk("out_pc", out_pc, sb[0][95:32]);
      chk("out_inst", 64'(out_inst), 64'(sb[0][31:0]));
    end
    @(posedge clk);
    if (reset) begin
      mpc = RST_PC; mcount = 0; sb.delete();
    end else if (redirect_valid) begin
      mpc = {redirect_pc[63:2], 2'b00}; mcount = 0; sb.delete();
    end else begin
      do_pop  = exp_valid && out_ready;
      do_push = exp_en && icache_valid;
      if (do_pop) begin
        if (record) popped.push_back(sb[0][95:32]);
        void'(sb.pop_front());
        mcount--;
      end
      if (do_push) begin
        sb.push_back({mpc, inst_of(mpc)});
        mpc = mpc + 64'd4;
        mcount++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(logic r, logic h, logic rv, logic [63:0] rp, logic rdy);
    reset = r; icache_valid = h; redirect_valid = rv; redirect_pc = rp; out_ready = rdy;
  endtask

  initial begin
    drive(1, 1, 0, 64'h0, 0);
    @(negedge clk);
    // reset with hits pending
    repeat (2) cycle();
    // fill the queue: four pushes then enable drops, pc holds at 0x1010
    drive(0, 1, 0, 64'h0, 0);
    repeat (6) cycle();
    chk("full_fetch_addr", fetch_addr, 64'h1010);
    // one-cycle pop from full; fetch resumes the cycle after
    drive(0, 1, 0, 64'h0, 1);
    cycle();
    drive(0, 1, 0, 64'h0, 0);
    repeat (3) cycle();
    // miss for 5 cycles at 0x2000, then a hit
    drive(0, 0, 1, 64'h2000, 0);
    cycle();
    drive(0, 0, 0, 64'h0, 0);
    repeat (5) cycle();
    drive(0, 1, 0, 64'h0, 0);
    cycle();
    drive(0, 0, 0, 64'h0, 0);
    cycle();
    chk("miss_head_pc", out_pc, 64'h2000);
    // grow to 3 entries, then redirect with a concurrent hit and pop
    drive(0, 1, 0, 64'h0, 0);
    repeat (2) cycle();
    drive(0, 1, 1, 64'h8002, 1);
    cycle();
    drive(0, 0, 0, 64'h0, 0);
    chk("redir_fetch_addr", fetch_addr, 64'h8000);
    chk("redir_out_valid", 64'(out_valid), 64'h0);
    cycle();
    // pointer wrap: 10 instructions streamed with out_ready held
    drive(0, 0, 1, 64'h1000, 1);
    cycle();
    record = 1'b1;
    drive(0, 1, 0, 64'h0, 1);
    repeat (10) cycle();
    drive(0, 0, 0, 64'h0, 1);
    repeat (2) cycle();
    record = 1'b0;
    chk("wrap_count", 64'(popped.size()), 64'd10);
    for (int i = 0; i < 10 && i < popped.size(); i++)
      chk("wrap_seq", popped[i], 64'h1000 + 64'(4 * i));
    // reset together with redirect and a hit
    drive(0, 1, 0, 64'h0, 0);
    repeat (2) cycle();
    drive(1, 1, 1, 64'h9000, 1);
    cycle();
    drive(0, 0, 0, 64'h0, 0);
    chk("rst_prio_fetch_addr", fetch_addr, RST_PC);
    chk("rst_prio_out_valid", 64'(out_valid), 64'h0);
    repeat (2) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
